fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_fetch_queue.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch unit with an in-order instruction queue.
//
// Issues word-aligned fetch requests to instruction memory and keeps at most
// DEPTH instructions in flight, counting both queued entries and outstanding
// requests. Returned words are queued with their addresses and presented to
// the core in order. A redirect flushes the queue and restarts fetch at the
// new address. Responses to requests issued before the redirect are
// discarded while the unit waits in FLUSH.
//
// Optional feature (compile-time macro FETCH_QUEUE_BYPASS_EN):
//   When this macro is defined, a response that arrives in RUN while the queue
//   is empty is shown on instr_* in the same cycle. It is only enqueued if the
//   core does not accept it in that cycle.
//
// Parameters:
//   DEPTH    queue capacity in entries (power of two, >= 2)
//   RESET_PC first fetch address after reset
//
// Ports:
//   clk                         rising-edge clock
//   rst                         asynchronous reset, active low
//   redirect_valid/redirect_pc  restart fetch at redirect_pc
//   mem_req_valid/ready/addr    instruction-memory request channel
//   mem_rsp_valid/data          in-order instruction-memory responses
//   instr_valid/ready           instruction handshake toward the core
//   instr_data/instr_pc         queue-head instruction word and its address

module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [31:0] RESET_BASE = RESET_PC & 32'hFFFF_FFFC;

  logic [1:0]    state, state_nxt;
  logic [31:0]   fetch_pc, rsp_pc;
  logic [CW-1:0] count, outstanding, out_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_addr [DEPTH];

  logic [31:0]   redirect_base;
  logic [CW:0]   inflight;
  logic          in_run, flush, req_fire, rsp_seen, rsp_take;
  logic          head_valid, bypass, pop, q_pop, push;

  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;
  assign in_run        = (state == RUN);
  assign flush         = redirect_valid && (state != IDLE);
  assign inflight      = {1'b0, count} + {1'b0, outstanding};

  assign mem_req_valid = in_run && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Any response seen with a request outstanding retires that request.
  // Only responses in RUN that do not coincide with a redirect are kept.
  assign rsp_seen = mem_rsp_valid && (state != IDLE) && (outstanding != '0);
  assign rsp_take = rsp_seen && in_run && !redirect_valid;

  assign head_valid = in_run && (count != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = rsp_take && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign pop   = instr_valid && instr_ready;
  assign q_pop = pop && head_valid;
  // A bypassed word taken by the core in the same cycle never occupies a slot.
  assign push  = rsp_take && !(bypass && instr_ready);

  always_comb begin
    instr_valid = head_valid || bypass;
    instr_data  = '0;
    instr_pc    = '0;
    if (head_valid) begin
      instr_data = q_data[rd_ptr];
      instr_pc   = q_addr[rd_ptr];
    end else if (bypass) begin
      instr_data = mem_rsp_data;
      instr_pc   = rsp_pc;
    end
  end

  always_comb begin
    out_nxt = outstanding;
    if (req_fire) out_nxt = out_nxt + CW'(1);
    if (rsp_seen) out_nxt = out_nxt - CW'(1);

    state_nxt = state;
    case (state)
      IDLE:  state_nxt = RUN;
      // A redirect and the FLUSH state both resolve on outstanding after this
      // cycle's response. Once nothing is left in flight, fetch resumes.
      RUN:   if (redirect_valid) state_nxt = (out_nxt == '0) ? RUN : FLUSH;
      FLUSH: if (out_nxt == '0) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_BASE;
      rsp_pc      <= RESET_BASE;
      count       <= '0;
      outstanding <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (flush) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_take) rsp_pc   <= rsp_pc + 32'd4;
        if (push)     wr_ptr   <= wr_ptr + AW'(1);
        if (q_pop)    rd_ptr   <= rd_ptr + AW'(1);
        if (push && !q_pop)      count <= count + CW'(1);
        else if (!push && q_pop) count <= count - CW'(1);
      end
    end
  end

  // Payload storage needs no reset: outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      q_data[wr_ptr] <= mem_rsp_data;
      q_addr[wr_ptr] <= rsp_pc;
    end
  end

  push_never_overflows: assert property (@(posedge clk) disable iff (!rst)
    !(push && !q_pop && (count == CW'(DEPTH))));

  inflight_bounded: assert property (@(posedge clk) disable iff (!rst)
    inflight <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  int unsigned total = 0;
  int unsigned passed = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // Memory image: each word is a distinct function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: requests issued but not yet answered (tagged with the
  // redirect epoch they belong to) and the queue of instruction addresses
  // the core is still owed.
  typedef struct { logic [31:0] addr; int unsigned epoch; } pend_t;
  pend_t       pending[$];
  logic [31:0] q_pc[$];
  logic [31:0] m_fetch;
  int unsigned epoch = 0;
  bit          m_idle = 1'b1;

  int unsigned p_ready = 0, p_rsp = 0, p_instr = 0, p_redirect = 0;
  bit          redir_once = 1'b0;
  logic [31:0] redir_target = '0;
  bit          stale_rsp = 1'b0;
  bit          rsp_from_pending = 1'b0;

  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          cyc = 0;
  int          first_valid_cyc = -1;
  int          first_req_cyc = -1;
  int unsigned iv_seen = 0;

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
    first_valid_cyc = -1;
    first_req_cyc = -1;
    iv_seen = 0;
  endtask

  task automatic model_reset();
    pending.delete();
    q_pc.delete();
    m_fetch = RESET_PC & 32'hFFFF_FFFC;
    epoch++;
    m_idle = 1'b1;
    redir_once = 1'b0;
    clear_logs();
  endtask

  task automatic drive_inputs();
    mem_req_ready = ($urandom_range(99) < p_ready);
    instr_ready   = ($urandom_range(99) < p_instr);
    rsp_from_pending = 1'b0;
    if (stale_rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
    end else if (pending.size() != 0 && $urandom_range(99) < p_rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pending[0].addr);
      rsp_from_pending = 1'b1;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    redirect_valid = 1'b0;
    if (!m_idle && rst) begin
      if (redir_once) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_target;
        redir_once     = 1'b0;
      end else if ($urandom_range(99) < p_redirect) begin
        redirect_valid = 1'b1;
        case ($urandom_range(3))
          0: redirect_pc = $urandom;
          1: redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15);
          2: redirect_pc = $urandom_range(255);
          default: redirect_pc = $urandom & 32'hFFFF_FFFC;
        endcase
      end
    end
  endtask

  // Hold reset for two edges, then release it just after a rising edge.
  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    drive_inputs();
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then retire
  // the handshakes into the model at the rising edge and drive new inputs.
  task automatic cycle();
    bit flushing, exp_req, exp_iv, byp, fire, pop, rsp, redir;
    logic [31:0] exp_pc, rpc;
    pend_t p;
    @(negedge clk);
    flushing = 1'b0;
    foreach (pending[i]) if (pending[i].epoch != epoch) flushing = 1'b1;
    exp_req = !m_idle && !flushing && !redirect_valid &&
              (pending.size() + q_pc.size() < DEPTH);
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = !m_idle && !flushing && !redirect_valid && (q_pc.size() == 0) &&
          mem_rsp_valid && rsp_from_pending;
`endif
    exp_iv = !m_idle && !flushing && (q_pc.size() != 0 || byp);
    exp_pc = '0;
    if (q_pc.size() != 0) exp_pc = q_pc[0];
    else if (byp) exp_pc = pending[0].addr;

    total++;
    if (mem_req_valid !== exp_req)
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, mem_req_valid, exp_req);
    else passed++;
    if (exp_req) begin
      total++;
      if (mem_req_addr !== m_fetch)
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, mem_req_addr, m_fetch);
      else passed++;
    end
    total++;
    if (instr_valid !== exp_iv)
      $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_iv);
    else passed++;
    if (exp_iv) begin
      total++;
      if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc))
        $display("FAIL instr_word cyc=%0d got=%h/%h exp=%h/%h", cyc,
                 instr_pc, instr_data, exp_pc, mem_word(exp_pc));
      else passed++;
    end

    fire  = mem_req_valid && mem_req_ready;
    pop   = exp_iv && instr_valid && instr_ready;
    rsp   = mem_rsp_valid && rsp_from_pending;
    redir = redirect_valid;
    rpc   = redirect_pc;
    if (instr_valid) begin
      iv_seen++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (fire) begin
      req_log.push_back(mem_req_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (pop) pop_log.push_back(instr_pc);

    @(posedge clk);
    if (pop && q_pc.size() != 0) void'(q_pc.pop_front());
    if (rsp) begin
      p = pending.pop_front();
      if (!m_idle && !redir && p.epoch == epoch && !(byp && pop))
        q_pc.push_back(p.addr);
    end
    if (redir && !m_idle) begin
      epoch++;
      q_pc.delete();
      m_fetch = rpc & 32'hFFFF_FFFC;
    end
    if (fire) begin
      pending.push_back(pend_t'{m_fetch, epoch});
      m_fetch = m_fetch + 32'd4;
    end
    m_idle = 1'b0;
    cyc++;
    #1;
    drive_inputs();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL reset_valids got=%b/%b exp=0/0", mem_req_valid, instr_valid);
    else passed++;
    total++;
    if (instr_data !== '0 || instr_pc !== '0)
      $display("FAIL reset_instr got=%h/%h exp=0/0", instr_data, instr_pc);
    else passed++;
    total++;
    if (mem_req_addr !== RESET_PC)
      $display("FAIL reset_addr got=%h exp=%h", mem_req_addr, RESET_PC);
    else passed++;
    p_ready = 0; p_rsp = 0; p_instr = 0; p_redirect = 0;
    apply_reset();
    repeat (3) cycle();
  endtask

  task automatic test_stream();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8; exp_a[3] = 32'hC;
    p_ready = 100; p_rsp = 100; p_instr = 100; p_redirect = 0;
    apply_reset();
    repeat (12) cycle();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (req_log.size() <= i || req_log[i] !== exp_a[i])
        $display("FAIL stream_req%0d got=%h exp=%h", i,
                 (req_log.size() > i) ? req_log[i] : 32'hXXXX_XXXX, exp_a[i]);
      else passed++;
    end
    total++;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (first_valid_cyc !== 2)
      $display("FAIL stream_latency got=%0d exp=2", first_valid_cyc);
`else
    if (first_valid_cyc !== 3)
      $display("FAIL stream_latency got=%0d exp=3", first_valid_cyc);
`endif
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8; exp_a[3] = 32'hC;
    p_ready = 100; p_rsp = 100; p_instr = 0; p_redirect = 0;
    apply_reset();
    repeat (12) cycle();
    total++;
    if (req_log.size() != DEPTH)
      $display("FAIL bp_req_count got=%0d exp=%0d", req_log.size(), DEPTH);
    else passed++;
    total++;
    if (mem_req_valid !== 1'b0)
      $display("FAIL bp_req_low got=%b exp=0", mem_req_valid);
    else passed++;
    p_instr = 100;
    repeat (8) cycle();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (pop_log.size() <= i || pop_log[i] !== exp_a[i])
        $display("FAIL bp_pop%0d got=%h exp=%h", i,
                 (pop_log.size() > i) ? pop_log[i] : 32'hXXXX_XXXX, exp_a[i]);
      else passed++;
    end
  endtask

  // Three requests left in flight, then one or two redirects before any of
  // them is answered.
  task automatic test_flush(input bit twice);
    logic [31:0] target;
    int exp_req_cyc;
    target = twice ? 32'h300 : 32'h100;
    p_ready = 100; p_rsp = 0; p_instr = 100; p_redirect = 0;
    apply_reset();
    repeat (3) cycle();
    p_ready = 0;
    cycle();
    redir_once = 1'b1;
    redir_target = twice ? 32'h200 : 32'h100;
    cycle();
    clear_logs();
    if (twice) begin
      redir_once = 1'b1;
      redir_target = 32'h300;
      cycle();
    end
    p_ready = 100; p_rsp = 100;
    repeat (12) cycle();
    exp_req_cyc = twice ? 10 : 9;
    total++;
    if (req_log.size() == 0 || req_log[0] !== target)
      $display("FAIL flush_target got=%h exp=%h",
               (req_log.size() > 0) ? req_log[0] : 32'hXXXX_XXXX, target);
    else passed++;
    total++;
    if (first_req_cyc != exp_req_cyc)
      $display("FAIL flush_req_cyc got=%0d exp=%0d", first_req_cyc, exp_req_cyc);
    else passed++;
    total++;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (first_valid_cyc != exp_req_cyc + 1)
      $display("FAIL flush_no_stale got=%0d exp=%0d", first_valid_cyc, exp_req_cyc + 1);
`else
    if (first_valid_cyc != exp_req_cyc + 2)
      $display("FAIL flush_no_stale got=%0d exp=%0d", first_valid_cyc, exp_req_cyc + 2);
`endif
    else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    p_ready = 100; p_rsp = 100; p_instr = 100; p_redirect = 0;
    apply_reset();
    redir_once = 1'b1;
    redir_target = 32'hFFFF_FFF8;
    repeat (10) cycle();
    total++;
    if (first_req_cyc != 2)
      $display("FAIL wrap_latency got=%0d exp=2", first_req_cyc);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (req_log.size() <= i || req_log[i] !== exp_a[i])
        $display("FAIL wrap_req%0d got=%h exp=%h", i,
                 (req_log.size() > i) ? req_log[i] : 32'hXXXX_XXXX, exp_a[i]);
      else passed++;
      total++;
      if (pop_log.size() <= i || pop_log[i] !== exp_a[i])
        $display("FAIL wrap_pop%0d got=%h exp=%h", i,
                 (pop_log.size() > i) ? pop_log[i] : 32'hXXXX_XXXX, exp_a[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    p_ready = 100; p_rsp = 100; p_instr = 0; p_redirect = 0;
    apply_reset();
    repeat (3) cycle();
    p_rsp = 0;
    repeat (3) cycle();
    total++;
    if (instr_valid !== 1'b1 || mem_req_valid !== 1'b0)
      $display("FAIL rmid_setup got=%b/%b exp=1/0", instr_valid, mem_req_valid);
    else passed++;
    #2;
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hBAD0_BAD0;
    #1;
    total++;
    if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL rmid_valids got=%b/%b exp=0/0", mem_req_valid, instr_valid);
    else passed++;
    total++;
    if (instr_data !== '0 || instr_pc !== '0 || mem_req_addr !== RESET_PC)
      $display("FAIL rmid_outputs got=%h/%h/%h exp=0/0/%h",
               instr_data, instr_pc, mem_req_addr, RESET_PC);
    else passed++;
    stale_rsp = 1'b1;
    apply_reset();
    stale_rsp = 1'b0;
    p_rsp = 100; p_instr = 100;
    repeat (8) cycle();
    total++;
    if (req_log.size() == 0 || req_log[0] !== RESET_PC)
      $display("FAIL rmid_restart got=%h exp=%h",
               (req_log.size() > 0) ? req_log[0] : 32'hXXXX_XXXX, RESET_PC);
    else passed++;
    total++;
    if (pop_log.size() == 0 || pop_log[0] !== RESET_PC)
      $display("FAIL rmid_first_pop got=%h exp=%h",
               (pop_log.size() > 0) ? pop_log[0] : 32'hXXXX_XXXX, RESET_PC);
    else passed++;
  endtask

  task automatic test_random();
    p_ready = 70; p_rsp = 60; p_instr = 60; p_redirect = 4;
    apply_reset();
    repeat (3000) cycle();
    total++;
    if (pop_log.size() < 100)
      $display("FAIL random_progress got=%0d exp>=100", pop_log.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush(1'b0);
    test_flush(1'b1);
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
